hdmi_period_scheduler: RTL and testbench

//  Sequences the three TMDS encoder/serializer channels through HDMI 1.x control, preamble,

---
 rtl/hdmi_tx_pkg.sv | 43 ++++
 rtl/hdmi_period_scheduler_if.sv | 36 +++
 rtl/hdmi_period_scheduler_pixel_delay_line.sv | 38 +++
 rtl/hdmi_period_scheduler.sv | 164 ++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_tx_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_tx_pkg
// Shared definitions for the HDMI transmit path: TMDS period-mode encodings,
// CTL preamble patterns, the video leading guard-band characters used by the
// per-channel encoders, the period scheduler FSM states and the word carried
// by the scheduler's pixel delay line.
// -----------------------------------------------------------------------------
package hdmi_tx_pkg;

  // Period mode select handed to every TMDS encoder.
  typedef enum logic [1:0] {
    TMDS_CTRL  = 2'b00,
    TMDS_GUARD = 2'b01,
    TMDS_VIDEO = 2'b10
  } tmds_mode_e;

  // {CTL3,CTL2,CTL1,CTL0}: idle control and the video-data-period preamble.
  localparam logic [3:0] CTL_IDLE     = 4'b0000;
  localparam logic [3:0] CTL_PREAMBLE = 4'b0001;

  // Scheduler period state.
  typedef enum logic [1:0] {
    ST_CTRL,
    ST_PREAMBLE,
    ST_GUARD,
    ST_VIDEO
  } period_state_e;

  // One pixel-clock slot of the delay line.
  typedef struct packed {
    logic        de;
    logic        vsync;
    logic        hsync;
    logic [23:0] pixel;
  } delay_word_t;

  // Video leading guard-band TMDS character for a channel (0 = blue).
  // Channels 0 and 2 share one character, channel 1 uses its complement.
  function automatic logic [9:0] video_guard_char(input int unsigned channel);
    return (channel == 1) ? 10'b0100110011 : 10'b1011001100;
  endfunction

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// -----------------------------------------------------------------------------
// hdmi_period_scheduler_if
// Signal bundle between the video timing generator and the period scheduler,
// plus the scheduler's encoder-facing outputs.
//   master : timing generator side - drives syncs/DE/pixel, observes outputs
//   slave  : period scheduler      - consumes syncs/DE/pixel, drives outputs
// Signals:
//   hsyncIn, vsyncIn, deIn, pixelIn[23:0]       timing generator -> scheduler
//   pixelOut[23:0], encoderDE, tmdsMode[1:0],
//   controlBus0/1/2[1:0], timingError           scheduler -> encoders
// -----------------------------------------------------------------------------
interface hdmi_period_scheduler_if;
  logic        hsyncIn;
  logic        vsyncIn;
  logic        deIn;
  logic [23:0] pixelIn;
  logic [23:0] pixelOut;
  logic        encoderDE;
  logic [1:0]  tmdsMode;
  logic [1:0]  controlBus0;
  logic [1:0]  controlBus1;
  logic [1:0]  controlBus2;
  logic        timingError;

  modport master (
    output hsyncIn, vsyncIn, deIn, pixelIn,
    input  pixelOut, encoderDE, tmdsMode, controlBus0, controlBus1, controlBus2,
           timingError
  );

  modport slave (
    input  hsyncIn, vsyncIn, deIn, pixelIn,
    output pixelOut, encoderDE, tmdsMode, controlBus0, controlBus1, controlBus2,
           timingError
  );
endinterface

// File: rtl/hdmi_period_scheduler_pixel_delay_line.sv
// -----------------------------------------------------------------------------
// pixel_delay_line
// DEPTH-stage shift register of WIDTH-bit words, advancing every clock.
//   clk   in          clock
//   rst   in          asynchronous active-high clear of every stage
//   d     in  WIDTH   word entering stage 0
//   q     out WIDTH   word leaving stage DEPTH-1 (d delayed DEPTH clocks)
// -----------------------------------------------------------------------------
module pixel_delay_line #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  // NOTE: blocking '=' in always_comb, non-blocking '<=' in always_ff; mixing
  // them up gives simulation/synthesis mismatches and order-dependent races.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  // NOTE: this storage is cleared on reset on purpose: a reset in the middle
  // of a line must not let stale pixels or a stale DE reach the encoders.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/hdmi_period_scheduler.sv
// -----------------------------------------------------------------------------
// hdmi_period_scheduler
// Sequences the TMDS channels through control, preamble, video guard band and
// video data periods. Pixels and syncs are delayed LEAD+1 clocks so that the
// preamble and guard band, started from the undelayed DE edge, end exactly
// when the first delayed pixel reaches the encoders.
//   pixelClock  in   sole clock
//   reset       in   asynchronous, active-high
//   bus         slave modport of hdmi_period_scheduler_if:
//                 in : hsyncIn, vsyncIn, deIn, pixelIn[23:0]
//                 out: pixelOut[23:0], encoderDE, tmdsMode[1:0],
//                      controlBus0 {vsync,hsync}, controlBus1 {CTL1,CTL0},
//                      controlBus2 {CTL3,CTL2}, timingError (sticky)
// -----------------------------------------------------------------------------
module hdmi_period_scheduler
  import hdmi_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GUARD_LEN    = 2,
  parameter int unsigned MIN_CTRL_LEN = 4,
  parameter bit          DVI_MODE     = 1'b0
) (
  input logic                    pixelClock,
  input logic                    reset,
  hdmi_period_scheduler_if.slave bus
);

  localparam int unsigned LEAD       = PREAMBLE_LEN + GUARD_LEN;
  localparam logic [3:0]  PRE_LAST   = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0]  GUARD_LAST = 4'(GUARD_LEN - 1);
  localparam logic [3:0]  MIN_RUN    = 4'(MIN_CTRL_LEN);

  delay_word_t dly_in;
  delay_word_t dly_out;

  assign dly_in = '{de: bus.deIn, vsync: bus.vsyncIn, hsync: bus.hsyncIn,
                    pixel: bus.pixelIn};

  pixel_delay_line #(
    .DEPTH (LEAD),
    .WIDTH ($bits(delay_word_t))
  ) u_delay (
    .clk (pixelClock),
    .rst (reset),
    .d   (dly_in),
    .q   (dly_out)
  );

  period_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    ctrl_run_q, ctrl_run_d;
  logic          de_in_q, de_in_d;
  tmds_mode_e    mode_q, mode_d;
  logic          enc_de_q, enc_de_d;
  logic [23:0]   pixel_q, pixel_d;
  logic [1:0]    sync_q, sync_d;
  logic [3:0]    ctl_q, ctl_d;
  logic          err_q, err_d;
  logic          de_rise;
  logic          start_ok;

  // dly_out is what the output register loads this clock, so dly_out.de is
  // the delayed DE of the next output cycle. Deciding on it keeps encoderDE
  // aligned with pixelOut without a second delay tap.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_run_d = '0;
    err_d      = err_q;
    de_in_d    = bus.deIn;

    de_rise  = bus.deIn & ~de_in_q;
    // A preamble needs enough plain control ahead of it and no video in flight.
    start_ok = (state_q == ST_CTRL) && (ctrl_run_q >= MIN_RUN) && !dly_out.de;
    if (de_rise && !start_ok) err_d = 1'b1;

    case (state_q)
      ST_CTRL: begin
        ctrl_run_d = (ctrl_run_q == 4'hF) ? ctrl_run_q : ctrl_run_q + 4'd1;
        // A line that arrived without a preamble still goes out on time.
        if (dly_out.de) begin
          state_d = ST_VIDEO;
        end else if (de_rise && start_ok && !DVI_MODE) begin
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = dly_out.de ? ST_VIDEO : ST_CTRL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_VIDEO: begin
        if (!dly_out.de) state_d = ST_CTRL;
      end
      default: state_d = ST_CTRL;
    endcase

    // Outputs follow the next state so they change on the same edge as it.
    mode_d   = TMDS_CTRL;
    enc_de_d = 1'b0;
    pixel_d  = '0;
    ctl_d    = CTL_IDLE;
    sync_d   = {dly_out.vsync, dly_out.hsync};
    case (state_d)
      ST_PREAMBLE: ctl_d  = CTL_PREAMBLE;
      ST_GUARD:    mode_d = TMDS_GUARD;
      ST_VIDEO: begin
        mode_d   = TMDS_VIDEO;
        enc_de_d = 1'b1;
        pixel_d  = dly_out.pixel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CTRL;
      cnt_q      <= '0;
      ctrl_run_q <= '0;
      de_in_q    <= 1'b0;
      mode_q     <= TMDS_CTRL;
      enc_de_q   <= 1'b0;
      pixel_q    <= '0;
      sync_q     <= '0;
      ctl_q      <= CTL_IDLE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_run_q <= ctrl_run_d;
      de_in_q    <= de_in_d;
      mode_q     <= mode_d;
      enc_de_q   <= enc_de_d;
      pixel_q    <= pixel_d;
      sync_q     <= sync_d;
      ctl_q      <= ctl_d;
      err_q      <= err_d;
    end
  end

  assign bus.pixelOut    = pixel_q;
  assign bus.encoderDE   = enc_de_q;
  assign bus.tmdsMode    = mode_q;
  assign bus.controlBus0 = sync_q;
  assign bus.controlBus1 = ctl_q[1:0];
  assign bus.controlBus2 = ctl_q[3:2];
  assign bus.timingError = err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hdmi_period_scheduler
// Drives an HDMI-mode and a DVI-mode scheduler with the same timing stream and
// compares every output of both, every cycle, against a reference model that
// works from the recorded input history: video is the input DE/pixel/sync
// LEAD+1 cycles late, an accepted DE edge at t puts a preamble on t+1..t+8
// and a guard band on t+9..t+10, and an edge is accepted only after at least
// MIN_CTRL plain control cycles with no video in flight.
// -----------------------------------------------------------------------------
module tb_hdmi_period_scheduler;

  localparam int LEAD = 10;
  localparam int PRE  = 8;
  localparam int MINC = 4;
  localparam int N    = 4096;

  logic pixelClock = 1'b0;
  logic reset      = 1'b1;

  always #5 pixelClock = ~pixelClock;

  hdmi_period_scheduler_if bus_hdmi ();
  hdmi_period_scheduler_if bus_dvi ();

  hdmi_period_scheduler #(
    .PREAMBLE_LEN (8), .GUARD_LEN (2), .MIN_CTRL_LEN (4), .DVI_MODE (1'b0)
  ) dut_hdmi (
    .pixelClock (pixelClock),
    .reset      (reset),
    .bus        (bus_hdmi)
  );

  hdmi_period_scheduler #(
    .PREAMBLE_LEN (8), .GUARD_LEN (2), .MIN_CTRL_LEN (4), .DVI_MODE (1'b1)
  ) dut_dvi (
    .pixelClock (pixelClock),
    .reset      (reset),
    .bus        (bus_dvi)
  );

  int checks   = 0;
  int errors   = 0;
  int n        = 0;   // current cycle index
  int r0       = 0;   // cycle in which reset was last released
  bit in_reset = 1'b1;

  bit          de_h  [N];
  bit          hs_h  [N];
  bit          vs_h  [N];
  logic [23:0] pix_h [N];
  bit          plain_h [2][N];
  bit          acc_h   [2][N];
  bit          err_m   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, n, obs, exp);
    end
  endtask

  function automatic bit valid_idx(input int m);
    return (m >= r0) && (m >= 0) && (m < N);
  endfunction
  function automatic bit de_at(input int m);
    return valid_idx(m) ? de_h[m] : 1'b0;
  endfunction
  function automatic bit hs_at(input int m);
    return valid_idx(m) ? hs_h[m] : 1'b0;
  endfunction
  function automatic bit vs_at(input int m);
    return valid_idx(m) ? vs_h[m] : 1'b0;
  endfunction
  function automatic logic [23:0] pix_at(input int m);
    return valid_idx(m) ? pix_h[m] : 24'h0;
  endfunction
  function automatic bit plain_at(input int d, input int m);
    return valid_idx(m) ? plain_h[d][m] : 1'b0;
  endfunction
  function automatic bit acc_at(input int d, input int m);
    return valid_idx(m) ? acc_h[d][m] : 1'b0;
  endfunction

  task automatic compare(input int d, input logic [1:0] e_mode, input logic e_de,
                         input logic [23:0] e_pix, input logic [1:0] e_cb0,
                         input logic [1:0] e_cb1, input logic [1:0] e_cb2,
                         input logic e_err);
    string nm;
    logic [1:0]  o_mode, o_cb0, o_cb1, o_cb2;
    logic        o_de, o_err;
    logic [23:0] o_pix;
    if (d == 0) begin
      nm = "hdmi";
      o_mode = bus_hdmi.tmdsMode;    o_de  = bus_hdmi.encoderDE;
      o_pix  = bus_hdmi.pixelOut;    o_cb0 = bus_hdmi.controlBus0;
      o_cb1  = bus_hdmi.controlBus1; o_cb2 = bus_hdmi.controlBus2;
      o_err  = bus_hdmi.timingError;
    end else begin
      nm = "dvi";
      o_mode = bus_dvi.tmdsMode;     o_de  = bus_dvi.encoderDE;
      o_pix  = bus_dvi.pixelOut;     o_cb0 = bus_dvi.controlBus0;
      o_cb1  = bus_dvi.controlBus1;  o_cb2 = bus_dvi.controlBus2;
      o_err  = bus_dvi.timingError;
    end
    check({nm, " tmdsMode"},    32'(o_mode), 32'(e_mode));
    check({nm, " encoderDE"},   32'(o_de),   32'(e_de));
    check({nm, " pixelOut"},    32'(o_pix),  32'(e_pix));
    check({nm, " controlBus0"}, 32'(o_cb0),  32'(e_cb0));
    check({nm, " controlBus1"}, 32'(o_cb1),  32'(e_cb1));
    check({nm, " controlBus2"}, 32'(o_cb2),  32'(e_cb2));
    check({nm, " timingError"}, 32'(o_err),  32'(e_err));
  endtask

  // Expected outputs of cycle n for DUT d (0 = HDMI, 1 = DVI).
  task automatic evaluate(input int d);
    int t;
    bit rise, ok, pre, grd, vid;
    if (in_reset) begin
      plain_h[d][n] = 1'b0;
      if (n >= 1) acc_h[d][n-1] = 1'b0;
      compare(d, 2'b00, 1'b0, 24'h0, 2'b00, 2'b00, 2'b00, 1'b0);
    end else begin
      t = n - 1;
      if (t >= r0) begin
        rise = de_at(t) && !de_at(t - 1);
        ok   = !de_at(t - LEAD);
        for (int k = 0; k <= MINC; k++) ok = ok && plain_at(d, t - k);
        acc_h[d][t] = rise && ok && (d == 0);
        if (rise && !ok) err_m[d] = 1'b1;
      end
      pre = 1'b0;
      grd = 1'b0;
      for (int j = 1; j <= LEAD; j++)
        if (acc_at(d, n - j)) begin
          if (j <= PRE) pre = 1'b1;
          else          grd = 1'b1;
        end
      vid = !pre && !grd && de_at(n - LEAD - 1);
      plain_h[d][n] = !pre && !grd && !vid;
      compare(d,
              vid ? 2'b10 : (grd ? 2'b01 : 2'b00),
              vid,
              vid ? pix_at(n - LEAD - 1) : 24'h0,
              {vs_at(n - LEAD - 1), hs_at(n - LEAD - 1)},
              pre ? 2'b01 : 2'b00,
              2'b00,
              err_m[d]);
    end
  endtask

  task automatic drive(input bit de, input bit hs, input bit vs, input logic [23:0] pix);
    bus_hdmi.deIn = de; bus_hdmi.hsyncIn = hs; bus_hdmi.vsyncIn = vs; bus_hdmi.pixelIn = pix;
    bus_dvi.deIn  = de; bus_dvi.hsyncIn  = hs; bus_dvi.vsyncIn  = vs; bus_dvi.pixelIn  = pix;
  endtask

  // One pixel clock: check the outputs of the new cycle, then apply reset
  // changes and the inputs for this cycle.
  task automatic tick(input bit rst_v, input bit de, input bit hs, input bit vs,
                      input logic [23:0] pix);
    @(posedge pixelClock);
    #1;
    n++;
    if (n >= N) begin
      $display("FAIL cycle budget exceeded at cycle %0d", n);
      $fatal(1, "cycle budget exceeded");
    end
    evaluate(0);
    evaluate(1);
    if (in_reset && !rst_v) begin
      reset    = 1'b0;
      in_reset = 1'b0;
      r0       = n;
      plain_h[0][n] = 1'b1;
      plain_h[1][n] = 1'b1;
    end else if (!in_reset && rst_v) begin
      reset    = 1'b1;
      in_reset = 1'b1;
      err_m[0] = 1'b0;
      err_m[1] = 1'b0;
      #1;
      compare(0, 2'b00, 1'b0, 24'h0, 2'b00, 2'b00, 2'b00, 1'b0);
      compare(1, 2'b00, 1'b0, 24'h0, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    drive(de, hs, vs, pix);
    de_h[n]  = de;
    hs_h[n]  = hs;
    vs_h[n]  = vs;
    pix_h[n] = pix;
  endtask

  task automatic blank(input int len);
    for (int i = 0; i < len; i++)
      tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
  endtask

  task automatic line(input int len, input bit ramp);
    for (int i = 0; i < len; i++)
      tick(1'b0, 1'b1, 1'($urandom), 1'($urandom), ramp ? 24'(i + 1) : 24'($urandom));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    // Reset held, then released with deIn low.
    repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    // Long blanking, then a 16-pixel ramp line.
    blank(20);
    line(16, 1'b1);
    blank(20);
    // Two lines three cycles apart: second line has no preamble/guard.
    line(16, 1'b0);
    blank(3);
    line(16, 1'b0);
    blank(25);
    // Random line lengths (including lines shorter than LEAD) and gaps.
    for (int i = 0; i < 12; i++) begin
      line($urandom_range(1, 20), 1'b0);
      blank((i % 3 == 0) ? $urandom_range(1, 5) : $urandom_range(15, 30));
    end
    blank(20);
    // Reset asserted on the fifth video cycle of a line.
    for (int i = 0; i < 15; i++)
      tick(1'b0, 1'b1, 1'($urandom), 1'($urandom), 24'($urandom));
    repeat (4) tick(1'b1, 1'b1, 1'($urandom), 1'($urandom), 24'($urandom));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    blank(20);
    line(16, 1'b1);
    blank(20);
    for (int i = 0; i < 6; i++) begin
      line($urandom_range(1, 20), 1'b0);
      blank($urandom_range(15, 30));
    end
    blank(15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
